adc_emulator: RTL
=================

ADC_EMULATOR -- requirements
Module: adc_emulator

Interface
REQ-001 The block SHALL be parameterised: CONV_CYCLES, 30, clk_100M cycles from CONVST fall to EOC assertion (range 1..255).
REQ-002 The block SHALL be parameterised: RD_LAT, 2, cycles from RD low detection to valid DB (range 1..15).
REQ-003 The block SHALL be parameterised: PU_CYCLES, 100, warm-up cycles after PD rise before conversions are accepted (range 1..255).
REQ-004 Port: clk_100M  input  1  100 MHz clock; all other inputs synchronous to it.
REQ-005 Port: Reset  input  1  asynchronous, active-low reset.
REQ-006 Port: CONVST_18  input  1  convert-start strobe; falling edge starts a conversion.
REQ-007 Port: RD_18  input  1  active-low read strobe.
REQ-008 Port: PD_18  input  1  power-down control; 0 means powered down, 1 means active.
REQ-009 Port: sample_in  input  8  value to be "converted".
REQ-010 Port: EOC_18  output  1  active-low end-of-conversion flag.
REQ-011 Port: DB_out  output  8  converted data bus.
REQ-012 Port: DB_oe  output  1  bus drive enable; 1 means DB_out is valid/driven.
REQ-013 Port: busy  output  1  high in states WARMUP and CONVERT.
REQ-014 Port: ovr_err  output  1  one-cycle pulse on an ignored CONVST fall.

Function
REQ-015 Edge detection SHALL use a one-cycle registered copy of CONVST_18 and RD_18; a fall is prev=1, cur=0.
REQ-016 The FSM SHALL have states PWRDN, WARMUP, IDLE, CONVERT, READY, READ.
REQ-017 PD_18=0 in any state SHALL force PWRDN on the next edge, with EOC_18=1 and DB_oe=0 while there.
REQ-018 PWRDN with PD_18=1 SHALL go to WARMUP; WARMUP SHALL go to IDLE exactly PU_CYCLES cycles later.
REQ-019 IDLE on a CONVST fall SHALL capture the sample into a data register and enter CONVERT.
REQ-020 EOC_18 SHALL go low exactly CONV_CYCLES cycles after the detecting edge, entering READY.
REQ-021 A CONVST fall during WARMUP or CONVERT SHALL be ignored and pulse ovr_err for one cycle.
REQ-022 A CONVST fall in READY SHALL discard the held data, recapture, drive EOC_18=1, and restart CONVERT without ovr_err.
REQ-023 READY with RD_18=0 SHALL enter READ.
REQ-024 DB_oe SHALL rise with DB_out=held data RD_LAT cycles after the RD low detection edge, and stay high while RD_18=0.
REQ-025 An RD rise in READ SHALL, on the next edge, set EOC_18=1 and DB_oe=0, and return to IDLE.
REQ-026 An RD rise before RD_LAT expires SHALL still return to IDLE, with DB_oe never asserted.
REQ-027 RD_18=0 outside READY/READ SHALL have no effect; DB_oe SHALL stay 0.
REQ-028 A simultaneous CONVST fall and RD low in READY SHALL give priority to the CONVST fall (REQ-022).
REQ-029 DB_out SHALL be 8'h00 whenever DB_oe=0.

Reset
REQ-030 Reset=0 SHALL asynchronously set: state PWRDN, EOC_18=1, DB_out=8'h00, DB_oe=0, busy=0, ovr_err=0, all counters and the data register 0, edge registers 1.
REQ-031 Reset asserted mid-conversion or mid-read SHALL abandon the operation; after release the block SHALL follow REQ-018 from PWRDN.

Configuration
REQ-032 With macro ADC_EMU_RAMP_EN defined, the captured value SHALL be an internal 8-bit ramp: 0 after reset, +1 per accepted conversion, wrapping 255->0, with sample_in ignored; without it, sample_in SHALL be captured.

Verification
REQ-033 Bench check: reset, PD_18=1 -> busy high for 100 cycles, then IDLE; a CONVST fall at that point is accepted.
REQ-034 Bench check: sample_in=8'hA5, CONVST fall at cycle T -> EOC_18 low at T+30; RD low at cycle R -> DB_oe=1 with DB_out=8'hA5 at R+2; RD rise -> EOC_18=1 and DB_oe=0 next cycle.
REQ-035 Bench check: CONVST fall at T+10 of a conversion -> ovr_err one-cycle pulse, EOC_18 still low at T+30.
REQ-036 Bench check: PD_18=0 during READ -> DB_oe=0 and EOC_18=1 next cycle; with PD_18=1 again, WARMUP of 100 cycles.
REQ-037 Bench check: ADC_EMU_RAMP_EN defined, three full conversions after reset -> DB_out reads 8'h00, 8'h01, 8'h02; 256 conversions wrap back to 8'h00.
REQ-038 Bench check: Reset pulsed low during CONVERT -> all outputs at reset values immediately, no EOC_18 low afterwards without a new CONVST.

Source files
------------

// File: rtl/adc_emulator.sv
// Cycle-accurate emulator of a strobe-driven 8-bit ADC (CONVST/EOC/RD/PD handshake).
// Optional build macro ADC_EMU_RAMP_EN: captured value is an internal ramp instead of sample_in.
`timescale 1ns/1ps
module adc_emulator #(
  parameter int CONV_CYCLES = 30,
  parameter int RD_LAT      = 2,
  parameter int PU_CYCLES   = 100
) (
  input  logic       clk_100M,
  input  logic       Reset,
  input  logic       CONVST_18,
  input  logic       RD_18,
  input  logic       PD_18,
  input  logic [7:0] sample_in,
  output logic       EOC_18,
  output logic [7:0] DB_out,
  output logic       DB_oe,
  output logic       busy,
  output logic       ovr_err
);

  typedef enum logic [2:0] {
    PWRDN, WARMUP, IDLE, CONVERT, READY, READ
  } state_t;

  // Counter holds k-1 at the k-th edge after entering a timed state.
  localparam logic [7:0] CONV_LAST = 8'(CONV_CYCLES - 1);
  localparam logic [7:0] RD_LAST   = 8'(RD_LAT - 1);
  localparam logic [7:0] PU_LAST   = 8'(PU_CYCLES - 1);

  state_t     state_q;
  logic       conv_prev_q;
  logic       rd_prev_q;
  logic [7:0] cnt_q;
  logic [7:0] data_q;
  logic [7:0] sample_d;
  logic       conv_fall;
  logic       rd_rise;

  assign conv_fall = conv_prev_q & ~CONVST_18;
  assign rd_rise   = ~rd_prev_q & RD_18;

`ifdef ADC_EMU_RAMP_EN
  logic [7:0] ramp_q;
  assign sample_d = ramp_q;
`else
  assign sample_d = sample_in;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk_100M or negedge Reset) begin
    if (!Reset) begin
      // NOTE: the data register is a plain flop (not a memory), so it is
      // reset along with the control state to give a defined bus value.
      state_q     <= PWRDN;
      conv_prev_q <= 1'b1;
      rd_prev_q   <= 1'b1;
      cnt_q       <= 8'h00;
      data_q      <= 8'h00;
      EOC_18      <= 1'b1;
      DB_out      <= 8'h00;
      DB_oe       <= 1'b0;
      busy        <= 1'b0;
      ovr_err     <= 1'b0;
`ifdef ADC_EMU_RAMP_EN
      ramp_q      <= 8'h00;
`endif
    end else begin
      conv_prev_q <= CONVST_18;
      rd_prev_q   <= RD_18;
      ovr_err     <= 1'b0;
      if (!PD_18) begin
        state_q <= PWRDN;
        cnt_q   <= 8'h00;
        EOC_18  <= 1'b1;
        DB_out  <= 8'h00;
        DB_oe   <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          PWRDN: begin
            state_q <= WARMUP;
            cnt_q   <= 8'h00;
            busy    <= 1'b1;
          end
          WARMUP: begin
            if (conv_fall) ovr_err <= 1'b1;
            if (cnt_q == PU_LAST) begin
              state_q <= IDLE;
              busy    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          IDLE, READY: begin
            // A convert strobe wins over a simultaneous read in READY.
            if (conv_fall) begin
              state_q <= CONVERT;
              cnt_q   <= 8'h00;
              data_q  <= sample_d;
              EOC_18  <= 1'b1;
              busy    <= 1'b1;
`ifdef ADC_EMU_RAMP_EN
              ramp_q  <= ramp_q + 8'd1;
`endif
            end else if (state_q == READY && !RD_18) begin
              state_q <= READ;
              cnt_q   <= 8'h00;
            end
          end
          CONVERT: begin
            if (conv_fall) ovr_err <= 1'b1;
            if (cnt_q == CONV_LAST) begin
              state_q <= READY;
              EOC_18  <= 1'b0;
              busy    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          READ: begin
            if (rd_rise) begin
              state_q <= IDLE;
              EOC_18  <= 1'b1;
              DB_out  <= 8'h00;
              DB_oe   <= 1'b0;
            end else if (!DB_oe) begin
              if (cnt_q == RD_LAST) begin
                DB_oe  <= 1'b1;
                DB_out <= data_q;
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
            end
          end
          default: state_q <= PWRDN;
        endcase
      end
    end
  end

endmodule
